operand_issue_stage: RTL and testbench

OPERAND_ISSUE_STAGE -- requirements
Module: operand_issue_stage

---
 rtl/operand_issue_stage_pkg.sv | 21 ++
 rtl/operand_bypass_mux.sv | 42 ++++
 rtl/operand_issue_stage.sv | 104 ++++++++++
 tb/tb_operand_issue_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_issue_stage_pkg.sv
// rtl/operand_issue_stage_pkg.sv - shared widths and forwarding-entry layout for the operand issue stage
package operand_issue_stage_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int RA_W_DEFAULT = 5;

    // Flattened forwarding entry, LSB first: valid, wen, data_ok, addr[RA_W], data[XLEN]
    localparam int FWD_VALID_BIT = 0;
    localparam int FWD_WEN_BIT   = 1;
    localparam int FWD_OK_BIT    = 2;
    localparam int FWD_ADDR_LSB  = 3;

    function automatic int fwd_data_lsb(input int ra_w);
        return FWD_ADDR_LSB + ra_w;
    endfunction

    function automatic int fwd_entry_w(input int ra_w, input int xlen);
        return FWD_ADDR_LSB + ra_w + xlen;
    endfunction

endpackage

// File: rtl/operand_bypass_mux.sv
// rtl/operand_bypass_mux.sv - selects one source operand from alt value, forwarding network or register file
module operand_bypass_mux
    import operand_issue_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int RA_W    = RA_W_DEFAULT,
    parameter int NUM_FWD = 3,
    localparam int EW     = fwd_entry_w(RA_W, XLEN),
    localparam int DLSB   = fwd_data_lsb(RA_W)
) (
    input  logic                   src_use,
    input  logic [RA_W-1:0]        src_addr,
    input  logic [XLEN-1:0]        src_alt,
    input  logic [XLEN-1:0]        rf_rdata,
    input  logic [NUM_FWD*EW-1:0]  fwd_entries,
    output logic [XLEN-1:0]        src_value,
    output logic                   src_ready
);

    logic [EW-1:0] entry;

    // Walk oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        src_value = '0;
        src_ready = 1'b1;
        entry     = '0;
        if (!src_use) begin
            src_value = src_alt;
        end else if (src_addr != '0) begin
            src_value = rf_rdata;
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                entry = fwd_entries[i*EW +: EW];
                if (entry[FWD_VALID_BIT] && entry[FWD_WEN_BIT] &&
                    entry[FWD_ADDR_LSB +: RA_W] == src_addr) begin
                    src_ready = entry[FWD_OK_BIT];
                    src_value = entry[FWD_OK_BIT] ? entry[DLSB +: XLEN] : '0;
                end
            end
        end
    end

endmodule

// File: rtl/operand_issue_stage.sv
// rtl/operand_issue_stage.sv - single-entry issue register with operand bypass and hazard stall counting
module operand_issue_stage
    import operand_issue_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int RA_W      = RA_W_DEFAULT,
    parameter int NUM_SRC   = 2,
    parameter int NUM_FWD   = 3,
    parameter int PAYLOAD_W = 96
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    input  logic [NUM_SRC-1:0]        in_src_use,
    input  logic [NUM_SRC*RA_W-1:0]   in_src_addr,
    input  logic [NUM_SRC*XLEN-1:0]   in_src_alt,
    output logic [NUM_SRC*RA_W-1:0]   rf_raddr,
    input  logic [NUM_SRC*XLEN-1:0]   rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_wen,
    input  logic [NUM_FWD-1:0]        fwd_data_ok,
    input  logic [NUM_FWD*RA_W-1:0]   fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PAYLOAD_W-1:0]      out_payload,
    output logic [NUM_SRC*XLEN-1:0]   out_src,
    output logic [15:0]               stall_cnt
);

    localparam int EW = fwd_entry_w(RA_W, XLEN);

    logic                    held_valid;
    logic [PAYLOAD_W-1:0]    held_payload;
    logic [NUM_SRC-1:0]      held_use;
    logic [NUM_SRC*RA_W-1:0] held_addr;
    logic [NUM_SRC*XLEN-1:0] held_alt;

    logic [NUM_FWD*EW-1:0]   fwd_entries;
    logic [NUM_SRC-1:0]      src_ready;
    logic                    all_ready;
    logic                    load;

    for (genvar f = 0; f < NUM_FWD; f++) begin : g_fwd_pack
        assign fwd_entries[f*EW +: EW] = {fwd_data[f*XLEN +: XLEN], fwd_addr[f*RA_W +: RA_W],
                                          fwd_data_ok[f], fwd_wen[f], fwd_valid[f]};
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        operand_bypass_mux #(
            .XLEN    (XLEN),
            .RA_W    (RA_W),
            .NUM_FWD (NUM_FWD)
        ) u_mux (
            .src_use     (held_use[s]),
            .src_addr    (held_addr[s*RA_W +: RA_W]),
            .src_alt     (held_alt[s*XLEN +: XLEN]),
            .rf_rdata    (rf_rdata[s*XLEN +: XLEN]),
            .fwd_entries (fwd_entries),
            .src_value   (out_src[s*XLEN +: XLEN]),
            .src_ready   (src_ready[s])
        );
    end

    assign all_ready   = &src_ready;
    assign out_valid   = held_valid & all_ready & ~flush;
    assign in_ready    = ~flush & (~held_valid | (out_valid & out_ready));
    assign load        = in_valid & in_ready;
    assign rf_raddr    = held_addr;
    assign out_payload = held_payload;

    always_ff @(posedge clk) begin
        if (reset) begin
            held_valid   <= 1'b0;
            held_payload <= '0;
            held_use     <= '0;
            held_addr    <= '0;
            held_alt     <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (load) begin
            held_valid   <= 1'b1;
            held_payload <= in_payload;
            held_use     <= in_src_use;
            held_addr    <= in_src_addr;
            held_alt     <= in_src_alt;
        end else if (out_valid && out_ready) begin
            held_valid <= 1'b0;
        end
    end

    // Only operand hazards count; downstream back-pressure does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (held_valid && !flush && !all_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
// tb/tb_operand_issue_stage.sv - randomized and directed checks of operand_issue_stage against a reference model
module tb_operand_issue_stage;

    localparam int XLEN      = 32;
    localparam int RA_W      = 5;
    localparam int NUM_SRC   = 2;
    localparam int NUM_FWD   = 3;
    localparam int PAYLOAD_W = 96;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      in_valid;
    logic                      in_ready;
    logic [PAYLOAD_W-1:0]      in_payload;
    logic [NUM_SRC-1:0]        in_src_use;
    logic [NUM_SRC*RA_W-1:0]   in_src_addr;
    logic [NUM_SRC*XLEN-1:0]   in_src_alt;
    logic [NUM_SRC*RA_W-1:0]   rf_raddr;
    logic [NUM_SRC*XLEN-1:0]   rf_rdata;
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD-1:0]        fwd_wen;
    logic [NUM_FWD-1:0]        fwd_data_ok;
    logic [NUM_FWD*RA_W-1:0]   fwd_addr;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [PAYLOAD_W-1:0]      out_payload;
    logic [NUM_SRC*XLEN-1:0]   out_src;
    logic [15:0]               stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_issue_stage #(
        .XLEN(XLEN), .RA_W(RA_W), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_src_use(in_src_use), .in_src_addr(in_src_addr), .in_src_alt(in_src_alt),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .fwd_valid(fwd_valid), .fwd_wen(fwd_wen), .fwd_data_ok(fwd_data_ok),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_payload(out_payload), .out_src(out_src), .stall_cnt(stall_cnt)
    );

    logic [XLEN-1:0] regfile [32];

    always_comb begin
        rf_rdata = '0;
        for (int s = 0; s < NUM_SRC; s++)
            rf_rdata[s*XLEN +: XLEN] = regfile[rf_raddr[s*RA_W +: RA_W]];
    end

    // Reference model: the held instruction as plain fields plus a saturating stall count.
    bit                   m_valid;
    logic [PAYLOAD_W-1:0] m_payload;
    bit                   m_use  [NUM_SRC];
    int                   m_addr [NUM_SRC];
    logic [XLEN-1:0]      m_alt  [NUM_SRC];
    int                   m_stall;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_src(input int s, output logic [XLEN-1:0] v, output bit rdy);
        v   = '0;
        rdy = 1'b1;
        if (!m_use[s]) begin
            v = m_alt[s];
            return;
        end
        if (m_addr[s] == 0) return;
        for (int f = 0; f < NUM_FWD; f++) begin
            if (fwd_valid[f] && fwd_wen[f] && int'(fwd_addr[f*RA_W +: RA_W]) == m_addr[s]) begin
                rdy = fwd_data_ok[f];
                v   = rdy ? fwd_data[f*XLEN +: XLEN] : '0;
                return;
            end
        end
        v = regfile[m_addr[s]];
    endfunction

    task automatic model_clear();
        m_valid   = 0;
        m_payload = '0;
        m_stall   = 0;
        for (int s = 0; s < NUM_SRC; s++) begin
            m_use[s] = 0; m_addr[s] = 0; m_alt[s] = '0;
        end
    endtask

    task automatic step();
        logic [XLEN-1:0] ev;
        bit r, all_rdy, ov, ir;
        @(negedge clk);
        all_rdy = 1;
        for (int s = 0; s < NUM_SRC; s++) begin
            model_src(s, ev, r);
            all_rdy &= r;
            check($sformatf("out_src%0d", s), 128'(out_src[s*XLEN +: XLEN]), 128'(ev));
            check($sformatf("rf_raddr%0d", s), 128'(rf_raddr[s*RA_W +: RA_W]), 128'(m_addr[s]));
        end
        ov = m_valid && all_rdy && !flush;
        ir = !flush && (!m_valid || (ov && out_ready));
        check("out_valid", 128'(out_valid), 128'(ov));
        check("in_ready", 128'(in_ready), 128'(ir));
        check("out_payload", 128'(out_payload), 128'(m_payload));
        check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
        if (reset) begin
            model_clear();
        end else begin
            if (m_valid && !flush && !all_rdy && m_stall < 65535) m_stall++;
            if (flush) m_valid = 0;
            else if (in_valid && ir) begin
                m_valid   = 1;
                m_payload = in_payload;
                for (int s = 0; s < NUM_SRC; s++) begin
                    m_use[s]  = in_src_use[s];
                    m_addr[s] = int'(in_src_addr[s*RA_W +: RA_W]);
                    m_alt[s]  = in_src_alt[s*XLEN +: XLEN];
                end
            end else if (ov && out_ready) m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int f, input bit v, input bit w, input bit ok,
                           input int addr, input logic [XLEN-1:0] data);
        fwd_valid[f]             = v;
        fwd_wen[f]               = w;
        fwd_data_ok[f]           = ok;
        fwd_addr[f*RA_W +: RA_W] = RA_W'(addr);
        fwd_data[f*XLEN +: XLEN] = data;
    endtask

    task automatic set_src(input int s, input bit use_reg, input int addr, input logic [XLEN-1:0] alt);
        in_src_use[s]               = use_reg;
        in_src_addr[s*RA_W +: RA_W] = RA_W'(addr);
        in_src_alt[s*XLEN +: XLEN]  = alt;
    endtask

    task automatic quiet();
        in_valid = 0; flush = 0; reset = 0; out_ready = 1;
        for (int f = 0; f < NUM_FWD; f++) set_fwd(f, 0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    logic [PAYLOAD_W-1:0] pay_a, pay_b;

    initial begin
        for (int i = 0; i < 32; i++) regfile[i] = $urandom;
        in_payload = '0; in_src_use = '0; in_src_addr = '0; in_src_alt = '0;
        quiet();
        model_clear();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        step();
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_stall", 128'(stall_cnt), 128'(0));

        // Youngest matching forwarder wins.
        set_src(0, 1, 3, '0); set_src(1, 1, 3, '0);
        set_fwd(0, 1, 1, 1, 3, 32'h11); set_fwd(1, 1, 1, 1, 3, 32'h22);
        in_payload = {$urandom, $urandom, $urandom};
        in_valid = 1;
        step();
        in_valid = 0;
        check("fwd_prio_src", 128'(out_src), 128'({32'h11, 32'h11}));
        check("fwd_prio_valid", 128'(out_valid), 128'(1));
        step();

        // Load-use stall resolving after two cycles.
        quiet(); do_reset();
        set_src(0, 1, 5, '0); set_src(1, 0, 0, 32'h1234);
        set_fwd(0, 1, 1, 0, 5, '0);
        in_valid = 1;
        step();
        in_valid = 0;
        check("lu_v0", 128'(out_valid), 128'(0));
        step();
        check("lu_v1", 128'(out_valid), 128'(0));
        step();
        set_fwd(0, 1, 1, 1, 5, 32'hABCD);
        #1;
        check("lu_v2", 128'(out_valid), 128'(1));
        check("lu_stall", 128'(stall_cnt), 128'(2));
        check("lu_src", 128'(out_src[XLEN-1:0]), 128'(32'hABCD));
        step();

        // Register zero ignores forwarding.
        quiet();
        set_src(0, 1, 0, '0);
        set_fwd(0, 1, 1, 1, 0, 32'hFFFF);
        in_valid = 1;
        step();
        in_valid = 0;
        check("x0_src", 128'(out_src[XLEN-1:0]), 128'(0));
        check("x0_valid", 128'(out_valid), 128'(1));
        step();

        // Flush beats a simultaneous load.
        quiet(); out_ready = 0;
        set_src(0, 0, 0, 32'h5); set_src(1, 0, 0, 32'h6);
        pay_a = {$urandom, $urandom, $urandom};
        in_payload = pay_a; in_valid = 1;
        step();
        pay_b = {$urandom, $urandom, $urandom};
        in_payload = pay_b; flush = 1;
        step();
        flush = 0; in_valid = 0;
        check("flush_valid", 128'(out_valid), 128'(0));
        check("flush_payload", 128'(out_payload), 128'(pay_a));
        step();

        // Back-pressure holds without counting stalls.
        quiet(); out_ready = 0;
        in_payload = pay_b; in_valid = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_payload", 128'(out_payload), 128'(pay_b));
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1; in_valid = 1; in_payload = pay_a;
        step();
        in_valid = 0;
        check("bp_next_payload", 128'(out_payload), 128'(pay_a));
        check("bp_next_valid", 128'(out_valid), 128'(1));
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 9) < 7);
            in_payload = {$urandom, $urandom, $urandom};
            for (int s = 0; s < NUM_SRC; s++)
                set_src(s, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom);
            for (int f = 0; f < NUM_FWD; f++)
                set_fwd(f, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                        $urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom);
            step();
        end

        // Stall counter saturation, then reset.
        quiet(); do_reset();
        set_src(0, 1, 9, '0); set_src(1, 0, 0, '0);
        set_fwd(0, 1, 1, 0, 9, '0);
        in_valid = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 70000; i++) step();
        check("sat_stall", 128'(stall_cnt), 128'(16'hFFFF));
        do_reset();
        check("sat_reset_stall", 128'(stall_cnt), 128'(0));
        check("sat_reset_valid", 128'(out_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
